// File: rtl/ds_scheduler.sv
// rtl/ds_scheduler.sv - three-source data scheduler with round-robin, fixed-priority and locked modes
module ds_scheduler #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] DS1,
    input  logic [DW-1:0] DS2,
    input  logic [DW-1:0] DS3,
    input  logic [2:0]    req,
    input  logic [1:0]    mode,
    input  logic [3:0]    switch_clk_cycles,
    input  logic [1:0]    lock_sel,
    output logic [DW-1:0] output_data,
    output logic          out_valid,
    output logic [2:0]    grant,
    output logic [1:0]    active_src
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_RR   = 2'b01;
    localparam logic [1:0] MODE_PRIO = 2'b10;
    localparam logic [1:0] MODE_LOCK = 2'b11;

    state_t        state_q;
    logic [2:0]    grant_q;
    logic [1:0]    active_q;
    logic [1:0]    ptr_q;
    logic [3:0]    cnt_q;
    logic [3:0]    dwell_q;
    logic [DW-1:0] data_q;
    logic          valid_q;

    logic [2:0]    eligible;
    logic [1:0]    rr_pick;
    logic [1:0]    prio_pick;
    logic [1:0]    pick_d;
    logic [2:0]    grant_d;
    logic [3:0]    dwell_d;
    logic [DW-1:0] sel_data;
    logic          granted_req;
    logic          arbitrate;

    // Cyclic successor over source codes 1..3
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd3) ? 2'd1 : s + 2'd1;
    endfunction

    function automatic logic [2:0] src_onehot(input logic [1:0] s);
        logic [2:0] oh;
        oh = 3'b000;
        case (s)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Eligibility, both pick policies and slot-boundary detection
    always_comb begin
        logic [1:0] c1;
        logic [1:0] c2;
        eligible = 3'b000;
        case (mode)
            MODE_RR, MODE_PRIO: eligible = req;
            MODE_LOCK:          eligible = req & src_onehot(lock_sel);
            MODE_HOLD:          eligible = 3'b000;
            default:            eligible = 3'b000;
        endcase

        // Search starts just after the last-served source; the pointer itself
        // comes last so a sole requester is re-granted.
        c1 = next_src(ptr_q);
        c2 = next_src(c1);
        if ((eligible & src_onehot(c1)) != 3'b000)
            rr_pick = c1;
        else if ((eligible & src_onehot(c2)) != 3'b000)
            rr_pick = c2;
        else if ((eligible & src_onehot(ptr_q)) != 3'b000)
            rr_pick = ptr_q;
        else
            rr_pick = 2'd0;

        if (eligible[0])
            prio_pick = 2'd1;
        else if (eligible[1])
            prio_pick = 2'd2;
        else if (eligible[2])
            prio_pick = 2'd3;
        else
            prio_pick = 2'd0;

        pick_d  = (mode == MODE_PRIO) ? prio_pick : rr_pick;
        grant_d = src_onehot(pick_d);
        dwell_d = (switch_clk_cycles == 4'd0) ? 4'd1 : switch_clk_cycles;

        case (active_q)
            2'd1:    sel_data = DS1;
            2'd2:    sel_data = DS2;
            2'd3:    sel_data = DS3;
            default: sel_data = data_q;
        endcase

        // A granted source dropping its request ends the slot early
        granted_req = |(grant_q & req);
        arbitrate   = (state_q == IDLE) ||
                      (cnt_q == dwell_q) || !granted_req;
    end

    // Scheduler FSM: grant slots, dwell counting and registered data path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 3'b000;
            active_q <= 2'd0;
            ptr_q    <= 2'd3;
            cnt_q    <= 4'd0;
            dwell_q  <= 4'd1;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (state_q == SERVE) begin
                data_q  <= sel_data;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end

            if (arbitrate) begin
                if (pick_d != 2'd0) begin
                    state_q  <= SERVE;
                    grant_q  <= grant_d;
                    active_q <= pick_d;
                    ptr_q    <= pick_d;
                    cnt_q    <= 4'd1;
                    dwell_q  <= dwell_d;
                end else begin
                    state_q  <= IDLE;
                    grant_q  <= 3'b000;
                    active_q <= 2'd0;
                    cnt_q    <= 4'd0;
                end
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign output_data = data_q;
    assign out_valid   = valid_q;
    assign grant       = grant_q;
    assign active_src  = active_q;

endmodule

// File: tb/tb_ds_scheduler.sv
// tb/tb_ds_scheduler.sv - scoreboard bench for ds_scheduler
module tb_ds_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] ds1, ds2, ds3;
    logic [2:0] req;
    logic [1:0] mode;
    logic [3:0] dsel;
    logic [1:0] lock_sel;
    logic [7:0] output_data;
    logic       out_valid;
    logic [2:0] grant;
    logic [1:0] active_src;

    int checks;
    int failures;

    typedef struct packed {
        logic [2:0] g;
        logic [1:0] a;
        logic       v;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] prev_g;
    logic [7:0] last_d;
    string      scen;

    ds_scheduler #(.DW(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .DS1               (ds1),
        .DS2               (ds2),
        .DS3               (ds3),
        .req               (req),
        .mode              (mode),
        .switch_clk_cycles (dsel),
        .lock_sel          (lock_sel),
        .output_data       (output_data),
        .out_valid         (out_valid),
        .grant             (grant),
        .active_src        (active_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ds_of(input logic [2:0] g);
        case (g)
            3'b001:  return ds1;
            3'b010:  return ds2;
            3'b100:  return ds3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] enc(input logic [2:0] g);
        case (g)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push n expected cycles with grant g; data/valid lag the grant by one cycle
    task automatic push(input logic [2:0] g, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.g = g;
            e.a = enc(g);
            e.v = (prev_g != 3'b000);
            e.d = (prev_g != 3'b000) ? ds_of(prev_g) : last_d;
            last_d = e.d;
            prev_g = g;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            chk({scen, ".grant"},  8'(grant),      8'(e.g));
            chk({scen, ".active"}, 8'(active_src), 8'(e.a));
            chk({scen, ".valid"},  8'(out_valid),  8'(e.v));
            chk({scen, ".data"},   output_data,    e.d);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({scen, ".rst_grant"},  8'(grant),      8'h00);
        chk({scen, ".rst_active"}, 8'(active_src), 8'h00);
        chk({scen, ".rst_valid"},  8'(out_valid),  8'h00);
        chk({scen, ".rst_data"},   output_data,    8'h00);
        @(negedge clk);
        rst    = 1'b0;
        prev_g = 3'b000;
        last_d = 8'h00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ds1      = 8'hAA;
        ds2      = 8'hBB;
        ds3      = 8'hCC;
        req      = 3'b000;
        mode     = 2'b00;
        dsel     = 4'd0;
        lock_sel = 2'd0;
        prev_g   = 3'b000;
        last_d   = 8'h00;
        scen     = "reset";

        @(negedge clk);
        chk("reset.grant",  8'(grant),      8'h00);
        chk("reset.active", 8'(active_src), 8'h00);
        chk("reset.valid",  8'(out_valid),  8'h00);
        chk("reset.data",   output_data,    8'h00);
        rst = 1'b0;

        // Round-robin over three requesters, dwell 6, then all drop
        scen = "rr3";
        mode = 2'b01; dsel = 4'd6; req = 3'b111;
        push(3'b001, 6); push(3'b010, 6); push(3'b100, 6); push(3'b001, 2);
        drain();
        req = 3'b000;
        push(3'b000, 2);
        drain();

        // Fixed priority: DS2 finishes its slot before DS1 takes over
        pulse_reset();
        scen = "prio";
        mode = 2'b10; dsel = 4'd3; req = 3'b110;
        push(3'b010, 2);
        drain();
        req = 3'b111;
        push(3'b010, 1); push(3'b001, 6);
        drain();

        // Zero dwell behaves as one cycle per slot
        pulse_reset();
        scen = "d0";
        mode = 2'b01; dsel = 4'd0; req = 3'b101;
        push(3'b001, 1); push(3'b100, 1); push(3'b001, 1);
        push(3'b100, 1); push(3'b001, 1); push(3'b100, 1);
        drain();

        // Granted source drops mid-slot: immediate handover without a bubble
        pulse_reset();
        scen = "drop";
        mode = 2'b01; dsel = 4'd6; req = 3'b011;
        push(3'b001, 2);
        drain();
        req = 3'b010;
        push(3'b010, 7);
        drain();

        // Locked mode, unlock takes effect only after the current slot; hold mode
        pulse_reset();
        scen = "lock";
        mode = 2'b11; dsel = 4'd2; lock_sel = 2'd2; req = 3'b111;
        push(3'b010, 5);
        drain();
        lock_sel = 2'd0;
        push(3'b010, 1); push(3'b000, 2);
        drain();
        scen = "hold";
        mode = 2'b00; lock_sel = 2'd2;
        push(3'b000, 2);
        drain();

        // Reset in the middle of a slot, then restart with DS1 alone
        pulse_reset();
        scen = "midrst";
        mode = 2'b01; dsel = 4'd6; req = 3'b001;
        push(3'b001, 3);
        drain();
        pulse_reset();
        push(3'b001, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
